// File: rtl/switch_debouncer_pkg.sv
// Shared constants for the switch conditioning front end and the pattern detector.
package switch_debouncer_pkg;

  localparam int CLK_HZ                = 50000000;
  localparam int DEBOUNCE_MS           = 20;
  localparam int DEFAULT_STABLE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;

  // Width of the detector's din bus; the debouncer output feeds it directly.
  localparam int DIN_W = 8;

  // Counter width able to hold 0 .. n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/switch_debouncer_debounce_bit.sv
// One switch bit: two-flop synchroniser, stability counter, debounced level
// and registered edge strobes.
module debounce_bit #(
  parameter int   STABLE_CYCLES = 4,
  parameter int   CNT_W         = 2,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din_raw,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic settled
);

  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(STABLE_CYCLES - 1);

  logic             s1_reg;
  logic             s2_reg;
  logic             dout_reg;
  logic             rise_reg;
  logic             fall_reg;
  logic             settled_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             dout_next;
  logic             update;

  // Plain flop chain into the clock domain; nothing sits between the stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg <= RESET_VAL;
      s2_reg <= RESET_VAL;
    end else begin
      s1_reg <= din_raw;
      s2_reg <= s1_reg;
    end
  end

  // Count consecutive cycles of disagreement; any agreement restarts from zero.
  always_comb begin
    update   = 1'b0;
    cnt_next = cnt_reg;
    if (s2_reg == dout_reg) begin
      cnt_next = '0;
    end else if (cnt_reg == TERMINAL) begin
      update   = 1'b1;
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
    dout_next = update ? s2_reg : dout_reg;
  end

  // Commit counter, level and strobes; settled looks at post-edge values so it
  // always agrees with the s2/dout pair visible after this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg     <= '0;
      dout_reg    <= RESET_VAL;
      rise_reg    <= 1'b0;
      fall_reg    <= 1'b0;
      settled_reg <= 1'b1;
    end else begin
      cnt_reg     <= cnt_next;
      dout_reg    <= dout_next;
      rise_reg    <= update & s2_reg;
      fall_reg    <= update & ~s2_reg;
      settled_reg <= (s1_reg == dout_next);
    end
  end

  assign dout    = dout_reg;
  assign rise    = rise_reg;
  assign fall    = fall_reg;
  assign settled = settled_reg;

endmodule

// File: rtl/switch_debouncer.sv
// Per-bit debouncer bank for raw switch inputs with combined change strobes.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int               WIDTH         = DIN_W,
  parameter int               STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din_raw,
  output logic [WIDTH-1:0] dout,
  output logic             changed,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             settled
);

  localparam int CNT_W = cnt_width(STABLE_CYCLES);

  logic [WIDTH-1:0] settled_bits;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      debounce_bit #(
        .STABLE_CYCLES(STABLE_CYCLES),
        .CNT_W        (CNT_W),
        .RESET_VAL    (RESET_VAL[gi])
      ) u_bit (
        .clk    (clk),
        .rst    (rst),
        .din_raw(din_raw[gi]),
        .dout   (dout[gi]),
        .rise   (rise[gi]),
        .fall   (fall[gi]),
        .settled(settled_bits[gi])
      );
    end
  endgenerate

  // Strobes come straight from per-bit flops, so these reductions carry no
  // path from din_raw.
  assign changed = |(rise | fall);
  assign settled = &settled_bits;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed scenarios plus randomized traffic, checked against a window-rule model.
module tb_switch_debouncer;

  localparam int         W  = 8;
  localparam int         SC = 4;
  localparam logic [7:0] RV = 8'h00;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din_raw = 8'hFF;
  logic [W-1:0] dout, rise, fall;
  logic         changed, settled;

  int tests = 0;
  int fails = 0;
  int pulses = 0;
  bit saw_low = 0;

  switch_debouncer #(.WIDTH(W), .STABLE_CYCLES(SC), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .din_raw(din_raw), .dout(dout),
    .changed(changed), .rise(rise), .fall(fall), .settled(settled)
  );

  always #10 clk = ~clk;

  // Reference model: a bit follows its synchronised input once the last SC
  // synchronised samples (seen since reset) all disagree with the current level.
  logic [W-1:0] m_s1 = RV, m_s2 = RV, m_dout = RV, m_rise = '0, m_fall = '0;
  logic         m_settled = 1'b1;
  logic [W-1:0] hist [SC];

  always @(posedge clk) begin
    if (rst) begin
      m_s1 = RV; m_s2 = RV; m_dout = RV; m_rise = '0; m_fall = '0; m_settled = 1'b1;
      for (int j = 0; j < SC; j++) hist[j] = RV;
    end else begin
      for (int j = SC - 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = m_s2;
      m_rise = '0; m_fall = '0;
      for (int i = 0; i < W; i++) begin
        bit all_differ;
        all_differ = 1;
        for (int j = 0; j < SC; j++) if (hist[j][i] == m_dout[i]) all_differ = 0;
        if (all_differ) begin
          if (m_dout[i]) m_fall[i] = 1'b1; else m_rise[i] = 1'b1;
        end
      end
      m_dout    = m_dout ^ (m_rise | m_fall);
      m_s2      = m_s1;
      m_s1      = din_raw;
      m_settled = (m_s2 == m_dout);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance n cycles, comparing every output against the model on the falling edge.
  task automatic step(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("dout", 32'(dout), 32'(m_dout));
      check("rise", 32'(rise), 32'(m_rise));
      check("fall", 32'(fall), 32'(m_fall));
      check("changed", 32'(changed), 32'((m_rise | m_fall) != '0));
      check("settled", 32'(settled), 32'(m_settled));
      check("rise_fall_excl", 32'(rise & fall), 32'(0));
      if (changed) pulses++;
      if (!settled) saw_low = 1;
    end
  endtask

  initial begin
    // 1: reset with FF held, then release
    step(3);
    check("t1_reset_dout", 32'(dout), 32'h00);
    check("t1_reset_settled", 32'(settled), 32'h1);
    rst = 1'b0; pulses = 0;
    step(5);
    check("t1_dout_before", 32'(dout), 32'h00);
    step(1);
    check("t1_dout", 32'(dout), 32'hFF);
    check("t1_rise", 32'(rise), 32'hFF);
    check("t1_changed", 32'(changed), 32'h1);
    step(1);
    check("t1_changed_drop", 32'(changed), 32'h0);
    check("t1_pulses", 32'(pulses), 32'd1);

    // return to 00, then 2: CE held
    din_raw = 8'h00; step(8);
    check("t2_start", 32'(dout), 32'h00);
    din_raw = 8'hCE; pulses = 0;
    step(5);
    check("t2_dout_before", 32'(dout), 32'h00);
    step(1);
    check("t2_dout", 32'(dout), 32'hCE);
    check("t2_rise", 32'(rise), 32'hCE);
    check("t2_fall", 32'(fall), 32'h00);
    step(3);
    check("t2_pulses", 32'(pulses), 32'd1);

    // 3: glitch on bit0
    din_raw = 8'h00; step(8);
    pulses = 0; saw_low = 0;
    din_raw = 8'h01; step(3);
    din_raw = 8'h00; step(8);
    check("t3_dout", 32'(dout), 32'h00);
    check("t3_pulses", 32'(pulses), 32'd0);
    check("t3_saw_low", 32'(saw_low), 32'd1);
    check("t3_settled", 32'(settled), 32'h1);

    // 4: bounce on bit7, then held high
    pulses = 0;
    for (int p = 0; p < 4; p++) begin
      din_raw = (p % 2 == 0) ? 8'h80 : 8'h00;
      step(2);
    end
    din_raw = 8'h80;
    step(5);
    check("t4_dout_before", 32'(dout[7]), 32'h0);
    step(1);
    check("t4_dout", 32'(dout[7]), 32'h1);
    step(3);
    check("t4_pulses", 32'(pulses), 32'd1);

    // 5: simultaneous rise on bit1 and fall on bit2
    din_raw = 8'h04; step(8);
    check("t5_start", 32'(dout), 32'h04);
    pulses = 0;
    din_raw = 8'h02; step(6);
    check("t5_dout", 32'(dout), 32'h02);
    check("t5_rise", 32'(rise), 32'h02);
    check("t5_fall", 32'(fall), 32'h04);
    step(3);
    check("t5_pulses", 32'(pulses), 32'd1);

    // 6: reset while counters sit at 2
    pulses = 0;
    din_raw = 8'hFF; step(4);
    rst = 1'b1; step(1);
    check("t6_dout", 32'(dout), 32'h00);
    check("t6_settled", 32'(settled), 32'h1);
    rst = 1'b0;
    step(5);
    check("t6_dout_before", 32'(dout), 32'h00);
    check("t6_no_strobe", 32'(pulses), 32'd0);
    step(1);
    check("t6_dout_after", 32'(dout), 32'hFF);

    // Randomized traffic with occasional resets
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 40) == 0) begin
        rst = 1'b1; step(1); rst = 1'b0;
      end
      if ($urandom_range(0, 3) == 0) din_raw = W'($urandom);
      else din_raw = din_raw ^ (W'(1) << $urandom_range(0, W - 1));
      step($urandom_range(1, 9));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
